// File: rtl/fir_pkg.sv
// Shared types and default sizing for the FIR tap loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fir_pkg;

  localparam int FIR_NTAPS  = 16;
  localparam int FIR_TAP_W  = 16;
  localparam int FIR_NBANKS = 2;

  // Loader sequencing states: idle, ROM latency fill, tap streaming, completion pulse.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    LOAD  = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

endpackage

// File: rtl/fir_tap_loader.sv
// Streams NTAPS coefficients of one ROM bank into the FIR tap port, gating the FIR sample enable meanwhile.
// Latency: accept -> PRIME (1) -> LOAD (NTAPS) -> DONE (1); back-to-back period NTAPS+3 cycles.
// Backpressure: none; requests while busy and sample strobes while busy are dropped, not queued.
// Optional: FIR_TAP_LOADER_DROPCNT_EN adds o_drop_cnt, a saturating count of strobes dropped in the latest load.
module fir_tap_loader
  import fir_pkg::*;
#(
  parameter int NTAPS  = FIR_NTAPS,
  parameter int TAP_W  = FIR_TAP_W,
  parameter int NBANKS = FIR_NBANKS,
  parameter int BANK_W = (NBANKS > 1) ? $clog2(NBANKS) : 1,
  parameter int ADDR_W = BANK_W + $clog2(NTAPS)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_load_req,
  input  logic [BANK_W-1:0] i_bank,
  output logic              o_busy,
  output logic              o_done,
  output logic [BANK_W-1:0] o_active_bank,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [TAP_W-1:0]  i_rom_data,
  output logic              o_tap_wr,
  output logic [TAP_W-1:0]  o_tap,
`ifdef FIR_TAP_LOADER_DROPCNT_EN
  output logic [7:0]        o_drop_cnt,
`endif
  input  logic              i_sample_ce,
  output logic              o_fir_ce
);

  localparam int IDX_W = ADDR_W - BANK_W;

  loader_state_t     state_q, state_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [BANK_W-1:0] active_bank_q, active_bank_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [IDX_W:0]    idx_ahead;
  logic              accept;

  assign accept = (state_q == IDLE) && i_load_req;

  // ROM index two ahead of the tap being written, wrapped modulo NTAPS (wrapped reads are unused).
  always_comb begin
    idx_ahead = {1'b0, cnt_q} + (IDX_W+1)'(2);
    if (idx_ahead >= (IDX_W+1)'(NTAPS)) begin
      idx_ahead = idx_ahead - (IDX_W+1)'(NTAPS);
    end
  end

  // Next-state and register-update logic for the load sequencer.
  always_comb begin
    state_d       = state_q;
    bank_d        = bank_q;
    active_bank_d = active_bank_q;
    cnt_d         = cnt_q;
    rom_addr_d    = rom_addr_q;
    case (state_q)
      IDLE: begin
        if (i_load_req) begin
          bank_d     = i_bank;
          rom_addr_d = {i_bank, IDX_W'(0)};
          state_d    = PRIME;
        end
      end
      PRIME: begin
        rom_addr_d = {bank_q, IDX_W'(1)};
        cnt_d      = '0;
        state_d    = LOAD;
      end
      LOAD: begin
        rom_addr_d = {bank_q, idx_ahead[IDX_W-1:0]};
        cnt_d      = cnt_q + IDX_W'(1);
        if (cnt_q == IDX_W'(NTAPS - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        active_bank_d = bank_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer registers; reset abandons any load in flight immediately.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q       <= IDLE;
      bank_q        <= '0;
      active_bank_q <= '0;
      cnt_q         <= '0;
      rom_addr_q    <= '0;
    end else begin
      state_q       <= state_d;
      bank_q        <= bank_d;
      active_bank_q <= active_bank_d;
      cnt_q         <= cnt_d;
      rom_addr_q    <= rom_addr_d;
    end
  end

  // Status and strobes decoded straight from the state register.
  assign o_busy        = (state_q != IDLE);
  assign o_done        = (state_q == DONE);
  assign o_tap_wr      = (state_q == LOAD);
  assign o_tap         = i_rom_data;
  assign o_rom_addr    = rom_addr_q;
  // The new bank is reported already in the DONE cycle, before active_bank_q catches up.
  assign o_active_bank = (state_q == DONE) ? bank_q : active_bank_q;
  assign o_fir_ce      = i_sample_ce && (state_q == IDLE);

`ifdef FIR_TAP_LOADER_DROPCNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // Count strobes suppressed while busy; restart on every accepted request, hold at 255.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (accept) begin
      drop_cnt_d = '0;
    end else if (o_busy && i_sample_ce && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  // Drop counter register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign o_drop_cnt = drop_cnt_q;
`else
  // Accept only feeds the drop counter; keep it referenced when that counter is absent.
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_fir_tap_loader.sv
// Self-checking bench for fir_tap_loader: registered ROM model, tap scoreboard, directed load scenarios.
module tb_fir_tap_loader;

  localparam int NTAPS  = 16;
  localparam int TAP_W  = 16;
  localparam int BANK_W = 1;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              i_reset;
  logic              i_load_req;
  logic [BANK_W-1:0] i_bank;
  logic              o_busy;
  logic              o_done;
  logic [BANK_W-1:0] o_active_bank;
  logic [ADDR_W-1:0] o_rom_addr;
  logic [TAP_W-1:0]  rom_data;
  logic              o_tap_wr;
  logic [TAP_W-1:0]  o_tap;
  logic              i_sample_ce;
  logic              o_fir_ce;
`ifdef FIR_TAP_LOADER_DROPCNT_EN
  logic [7:0]        o_drop_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int tap_cnt = 0;
  logic [TAP_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  fir_tap_loader dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_load_req    (i_load_req),
    .i_bank        (i_bank),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_active_bank (o_active_bank),
    .o_rom_addr    (o_rom_addr),
    .i_rom_data    (rom_data),
    .o_tap_wr      (o_tap_wr),
    .o_tap         (o_tap),
`ifdef FIR_TAP_LOADER_DROPCNT_EN
    .o_drop_cnt    (o_drop_cnt),
`endif
    .i_sample_ce   (i_sample_ce),
    .o_fir_ce      (o_fir_ce)
  );

  function automatic logic [TAP_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    return 16'h1000 + 16'(a) * 16'h0111;
  endfunction

  // Registered ROM: data for an address appears one cycle after it is presented.
  always @(posedge clk) rom_data <= rom_word(o_rom_addr);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, act, exp);
    end
  endtask

  task automatic push_bank(input logic [BANK_W-1:0] b);
    for (int i = 0; i < NTAPS; i++) exp_q.push_back(rom_word({b, 4'(i)}));
  endtask

  // Every tap write is popped against the expected ROM word order.
  always @(negedge clk) begin
    if (!i_reset && o_tap_wr) begin
      tap_cnt++;
      if (exp_q.size() == 0) check("tap_unexpected", 32'(exp_q.size()), 1);
      else check("tap", o_tap, exp_q.pop_front());
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One full load accepted at cycle 0 with sample strobe held high;
  // extra request pulses for the other bank at cycles ign1/ign2 must be ignored.
  task automatic load_and_check(input logic [BANK_W-1:0] b, input int ign1, input int ign2);
    int start_cnt;
    start_cnt = tap_cnt;
    i_sample_ce = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      i_load_req = (c == 0) || (c == ign1) || (c == ign2);
      i_bank     = (c == 0) ? b : ~b;
      if (c == 0) push_bank(b);
      @(negedge clk);
      check("busy",   o_busy,   (c >= 1 && c <= 18));
      check("done",   o_done,   (c == 18));
      check("tap_wr", o_tap_wr, (c >= 2 && c <= 17));
      check("fir_ce", o_fir_ce, (c == 0 || c >= 19));
      if (c == 1) check("addr_prime", o_rom_addr, {b, 4'd0});
      if (c == 2) check("addr_load0", o_rom_addr, {b, 4'd1});
      if (c >= 18) check("active_bank", o_active_bank, b);
`ifdef FIR_TAP_LOADER_DROPCNT_EN
      if (c == 1) check("drop_clear", o_drop_cnt, 0);
      if (c == 20) check("drop_cnt", o_drop_cnt, 18);
`endif
      next_cycle();
    end
    i_load_req = 1'b0;
    check("tap_count", tap_cnt - start_cnt, NTAPS);
    check("sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int start_cnt;
    i_reset = 1'b1; i_load_req = 1'b0; i_bank = '0; i_sample_ce = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",   o_busy, 0);
    check("rst_done",   o_done, 0);
    check("rst_tap_wr", o_tap_wr, 0);
    check("rst_addr",   o_rom_addr, 0);
    check("rst_active", o_active_bank, 0);
    i_reset = 1'b0;
    next_cycle();

    // Bank-1 load with continuous strobes: timing, tap order, CE gating.
    load_and_check(1'b1, -1, -1);

    // Reset in cycle 8 of a bank-1 load.
    start_cnt = tap_cnt;
    i_sample_ce = 1'b0;
    for (int c = 0; c < 8; c++) begin
      i_load_req = (c == 0);
      i_bank     = 1'b1;
      if (c == 0) push_bank(1'b1);
      next_cycle();
    end
    i_load_req = 1'b0;
    i_reset = 1'b1;
    #1;
    check("mid_rst_tap_wr", o_tap_wr, 0);
    check("mid_rst_busy",   o_busy, 0);
    check("mid_rst_active", o_active_bank, 0);
    check("mid_rst_addr",   o_rom_addr, 0);
    check("partial_taps",   tap_cnt - start_cnt, 6);
    check("pending_taps",   exp_q.size(), 10);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    i_reset = 1'b0;
    next_cycle();
    load_and_check(1'b0, -1, -1);

    // Requests for bank 0 in cycle 5 and in the DONE cycle are ignored.
    load_and_check(1'b1, 5, 18);

    // Back-to-back: bank 0 then bank 1 with request held high.
    start_cnt = tap_cnt;
    i_sample_ce = 1'b0;
    for (int c = 0; c <= 39; c++) begin
      i_load_req = (c <= 30);
      i_bank     = (c < 19) ? 1'b0 : 1'b1;
      if (c == 0)  push_bank(1'b0);
      if (c == 19) push_bank(1'b1);
      @(negedge clk);
      check("b2b_busy", o_busy, ((c >= 1 && c <= 18) || (c >= 20 && c <= 37)));
      check("b2b_done", o_done, (c == 18 || c == 37));
      if (c >= 18 && c <= 36) check("b2b_active0", o_active_bank, 0);
      if (c >= 37) check("b2b_active1", o_active_bank, 1);
      next_cycle();
    end
    i_load_req = 1'b0;
    check("b2b_taps", tap_cnt - start_cnt, 2 * NTAPS);
    check("b2b_sb_empty", exp_q.size(), 0);

`ifdef FIR_TAP_LOADER_DROPCNT_EN
    // Continuous loads under 300 strobes: count restarts each accept and tops out per load.
    i_sample_ce = 1'b1;
    i_bank = 1'b0;
    for (int c = 0; c < 300; c++) begin
      i_load_req = 1'b1;
      if (c % 19 == 0) push_bank(1'b0);
      @(negedge clk);
      if (c % 19 == 1) check("rep_drop_clear", o_drop_cnt, 0);
      if (c >= 19 && c % 19 == 0) check("rep_drop_full", o_drop_cnt, 18);
      next_cycle();
    end
    i_load_req = 1'b0;
    i_sample_ce = 1'b0;
    repeat (20) next_cycle();
    exp_q.delete();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
